// File: rtl/window_pkg.sv
// Shared constants for the sliding-window generator: border modes, FSM encoding
// and the counter-width helper.
package window_pkg;

  localparam int PAD_ZERO      = 0;
  localparam int PAD_REPLICATE = 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular delay line: dout presents the sample written DEPTH shifts earlier,
// so reading and overwriting the same slot yields a fixed DEPTH-sample delay.
module line_buffer
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int              AW       = cnt_w(DEPTH);
  localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[ptr] <= din;
      ptr      <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/window_gen_kxk.sv
// Sliding K x K neighbourhood generator over a raster pixel stream, with
// zero or edge-replicate border handling and an end-of-frame flush.
module window_gen_kxk
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int K          = 5,
  parameter int PAD_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [K*K*DATA_WIDTH-1:0]     window_o,
  output logic                          valid_o,
  output logic                          done_o
);

  localparam int H         = (K - 1) / 2;
  localparam int RW        = cnt_w(ROWS);
  localparam int CW        = cnt_w(COLS);
  localparam int KW        = cnt_w(K);
  localparam bit ZERO_FILL = (PAD_MODE == PAD_ZERO);

  localparam logic [RW-1:0] ROW_H    = RW'(H);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_H    = CW'(H);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  function automatic int clamp(input int v, input int n);
    if (v < 0)     return 0;
    if (v > n - 1) return n - 1;
    return v;
  endfunction

  logic [1:0]    state;
  logic [RW-1:0] row_in, row_out;
  logic [CW-1:0] col_in, col_out;
  logic          flushing, accept, shift_en, emit, last_in, last_out;

  logic [DATA_WIDTH-1:0]     pix_p0;
  logic [DATA_WIDTH-1:0]     lb_dout [K-1];
  logic [DATA_WIDTH-1:0]     win_p0  [K][K];
  logic [DATA_WIDTH-1:0]     win_nxt [K][K];
  logic [K*K*DATA_WIDTH-1:0] tap_nxt;
  logic [K*K*DATA_WIDTH-1:0] win_p1;
  logic                      vld_p1, done_p1;
  int                        ir, ic, sr, sc;

  assign flushing = (state == FLUSH);
  assign accept   = valid_i && !flushing;
  assign shift_en = accept || flushing;
  assign pix_p0   = flushing ? '0 : data_i;
  assign last_in  = (row_in == ROW_LAST) && (col_in == COL_LAST);
  assign last_out = (row_out == ROW_LAST) && (col_out == COL_LAST);
  assign emit     = flushing ||
                    (accept && ((state == RUN) || ((row_in == ROW_H) && (col_in == COL_H))));

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    logic [DATA_WIDTH-1:0] din;
    if (j == 0) begin : g_head
      assign din = pix_p0;
    end else begin : g_tail
      assign din = lb_dout[j-1];
    end
    line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (COLS)
    ) u_lb (
      .clk     (clk),
      .rst     (rst),
      .shift_en(shift_en),
      .din     (din),
      .dout    (lb_dout[j])
    );
  end

  // p0: raw tap array; bottom-right holds the newest pixel, each row above is one line older
  always_comb begin
    for (int wr = 0; wr < K; wr++)
      for (int wc = 0; wc < K; wc++)
        win_nxt[wr][wc] = win_p0[wr][wc];
    if (shift_en) begin
      for (int wr = 0; wr < K; wr++)
        for (int wc = 0; wc < K - 1; wc++)
          win_nxt[wr][wc] = win_p0[wr][wc+1];
      for (int wr = 0; wr < K - 1; wr++)
        win_nxt[wr][K-1] = lb_dout[K-2-wr];
      win_nxt[K-1][K-1] = pix_p0;
    end
  end

  // Raw taps that fall off the image may hold neighbouring-row or stale data;
  // a clamped coordinate always lands back inside the window, so replicate
  // mode simply re-reads the tap at the clamped position.
  always_comb begin
    tap_nxt = '0;
    ir = 0;
    ic = 0;
    sr = 0;
    sc = 0;
    for (int wr = 0; wr < K; wr++) begin
      for (int wc = 0; wc < K; wc++) begin
        ir = int'(row_out) + wr - H;
        ic = int'(col_out) + wc - H;
        sr = clamp(ir, ROWS) - int'(row_out) + H;
        sc = clamp(ic, COLS) - int'(col_out) + H;
        if (!ZERO_FILL || ((ir == clamp(ir, ROWS)) && (ic == clamp(ic, COLS))))
          tap_nxt[(wr*K+wc)*DATA_WIDTH +: DATA_WIDTH] = win_nxt[KW'(sr)][KW'(sc)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_in  <= '0;
      col_in  <= '0;
      row_out <= '0;
      col_out <= '0;
      for (int wr = 0; wr < K; wr++)
        for (int wc = 0; wc < K; wc++)
          win_p0[wr][wc] <= '0;
      win_p1  <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      if (shift_en)
        for (int wr = 0; wr < K; wr++)
          for (int wc = 0; wc < K; wc++)
            win_p0[wr][wc] <= win_nxt[wr][wc];

      if (accept) begin
        col_in <= (col_in == COL_LAST) ? '0 : col_in + CW'(1);
        if (col_in == COL_LAST)
          row_in <= (row_in == ROW_LAST) ? '0 : row_in + RW'(1);
      end

      // p1: registered padded window, centred at (row_out, col_out)
      vld_p1  <= emit;
      done_p1 <= emit && last_out;
      if (emit) begin
        win_p1  <= tap_nxt;
        col_out <= (col_out == COL_LAST) ? '0 : col_out + CW'(1);
        if (col_out == COL_LAST)
          row_out <= (row_out == ROW_LAST) ? '0 : row_out + RW'(1);
      end

      case (state)
        IDLE:    if (accept) state <= FILL;
        FILL:    if (accept && (row_in == ROW_H) && (col_in == COL_H)) state <= RUN;
        RUN:     if (accept && last_in) state <= FLUSH;
        FLUSH:   if (last_out) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign window_o = win_p1;
  assign valid_o  = vld_p1;
  assign done_o   = done_p1;

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: 3x3 zero/replicate on a 4x4 image and 5x5 zero on a 5x5 image.
module tb_window_gen_kxk;
  import window_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, va, vb;
  logic [7:0] da, db;
  logic [71:0]  w0, w1;
  logic [199:0] w2;
  logic v0, v1, v2, d0, d1, d2;

  window_gen_kxk #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .K(3), .PAD_MODE(PAD_ZERO)) u_zero (
    .clk(clk), .rst(rst), .valid_i(va), .data_i(da), .window_o(w0), .valid_o(v0), .done_o(d0));
  window_gen_kxk #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .K(3), .PAD_MODE(PAD_REPLICATE)) u_rep (
    .clk(clk), .rst(rst), .valid_i(va), .data_i(da), .window_o(w1), .valid_o(v1), .done_o(d1));
  window_gen_kxk #(.DATA_WIDTH(8), .ROWS(5), .COLS(5), .K(5), .PAD_MODE(PAD_ZERO)) u_k5 (
    .clk(clk), .rst(rst), .valid_i(vb), .data_i(db), .window_o(w2), .valid_o(v2), .done_o(d2));

  typedef struct {
    logic [199:0] win;
    logic         done;
    int           cyc;
    logic         pv;
  } rec_t;

  typedef struct {
    int dut;
    int win;
    int tap;
    int exp;
  } vec_t;

  rec_t q0[$], q1[$], q2[$], s0[$], s1[$], s2[$];
  vec_t tbl[$];
  int img_a[4][4];
  int img_b[5][5];
  int checks = 0, errors = 0, cyc = 0, acc6 = -1;
  logic pva = 1'b0, pvb = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pva <= va;
    pvb <= vb;
  end

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (v0) q0.push_back('{win: {128'b0, w0}, done: d0, cyc: cyc, pv: pva});
    if (v1) q1.push_back('{win: {128'b0, w1}, done: d1, cyc: cyc, pv: pva});
    if (v2) q2.push_back('{win: w2, done: d2, cyc: cyc, pv: pvb});
    if (d0) chk_int("done_without_valid_zero", int'(v0), 1);
    if (d1) chk_int("done_without_valid_rep", int'(v1), 1);
    if (d2) chk_int("done_without_valid_k5", int'(v2), 1);
  end

  function automatic int clampi(input int v, input int n);
    return (v < 0) ? 0 : ((v >= n) ? n - 1 : v);
  endfunction

  function automatic int pix(input int which, input int r, input int c);
    return (which == 2) ? img_b[r][c] : img_a[r][c];
  endfunction

  // Expected neighbourhood straight from image coordinates.
  function automatic logic [199:0] model_win(input int which, input int r, input int c);
    logic [199:0] w;
    int k, n, h, ir, ic, v;
    w = '0;
    k = (which == 2) ? 5 : 3;
    n = (which == 2) ? 5 : 4;
    h = (k - 1) / 2;
    for (int i = 0; i < k * k; i++) begin
      ir = r + i / k - h;
      ic = c + i % k - h;
      if (ir >= 0 && ir < n && ic >= 0 && ic < n) v = pix(which, ir, ic);
      else if (which == 1) v = pix(which, clampi(ir, n), clampi(ic, n));
      else v = 0;
      w[i*8 +: 8] = 8'(v);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input int mode, input int npix);
    int n;
    n = (sel == 0) ? 4 : 5;
    for (int p = 0; p < npix; p++) begin
      if (sel == 0) begin va = 1'b1; da = 8'(img_a[p/n][p%n]); end
      else begin vb = 1'b1; db = 8'(img_b[p/n][p%n]); end
      tick();
      if (sel == 0 && p == 5) acc6 = cyc;
      va = 1'b0;
      vb = 1'b0;
      if (mode == 1) tick();
      else if (mode == 2) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic check_frame(input string nm, input int which, input int frames);
    rec_t q[$];
    int cols, n, hc, tot, f;
    case (which)
      0:       q = q0;
      1:       q = q1;
      default: q = q2;
    endcase
    cols = (which == 2) ? 5 : 4;
    n    = cols * cols;
    hc   = (which == 2) ? 12 : 5;
    tot  = n * frames;
    chk_int({nm, "_count"}, q.size(), tot);
    for (int i = 0; i < tot && i < q.size(); i++) begin
      f = i % n;
      chk_vec($sformatf("%s_win%0d", nm, i), q[i].win, model_win(which, f / cols, f % cols));
      chk_int($sformatf("%s_done%0d", nm, i), int'(q[i].done), (f == n - 1) ? 1 : 0);
      if (f < n - hc)
        chk_int($sformatf("%s_after_accept%0d", nm, i), int'(q[i].pv), 1);
      else
        chk_int($sformatf("%s_flush_cyc%0d", nm, i), q[i].cyc, q[i-1].cyc + 1);
    end
  endtask

  task automatic set_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img_a[r][c] = 4 * r + c + 1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img_b[r][c] = 5 * r + c + 1;
  endtask

  task automatic add_win(input int dut, input int win, input int vals[9]);
    for (int i = 0; i < 9; i++) tbl.push_back('{dut, win, i, vals[i]});
  endtask

  initial begin
    int first_z[9], last_z[9], first_r[9], last_r[9];
    int found, act;
    logic [199:0] wv;

    first_z = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    last_z  = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    first_r = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
    last_r  = '{11, 12, 12, 15, 16, 16, 15, 16, 16};
    add_win(0, 0, first_z);
    add_win(0, 15, last_z);
    add_win(1, 0, first_r);
    add_win(1, 15, last_r);
    for (int i = 0; i < 25; i++) tbl.push_back('{2, 12, i, i + 1});
    tbl.push_back('{2, 0, 12, 1});
    tbl.push_back('{2, 0, 13, 2});
    tbl.push_back('{2, 0, 18, 7});
    tbl.push_back('{2, 0, 0, 0});

    rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
    set_ramp();
    repeat (3) tick();
    chk_int("reset_valid", int'(v0 | v1 | v2), 0);
    chk_int("reset_done", int'(d0 | d1 | d2), 0);
    chk_vec("reset_window", {w0, w1, w2} != '0 ? 200'd1 : 200'd0, 200'd0);
    rst = 1'b0;
    tick();

    // continuous frame, both border modes
    clear_q();
    drive(0, 0, 16);
    repeat (12) tick();
    check_frame("t1_zero", 0, 1);
    check_frame("t2_rep", 1, 1);
    if (q0.size() > 0) chk_int("t1_first_latency", q0[0].cyc, acc6);
    s0 = q0;
    s1 = q1;

    // valid every other cycle
    clear_q();
    drive(0, 1, 16);
    repeat (12) tick();
    check_frame("t3_gap", 0, 1);

    // reset after 7 pixels, then full replay
    clear_q();
    drive(0, 0, 7);
    rst = 1'b1;
    tick();
    chk_int("t4_rst_valid", int'(v0), 0);
    chk_int("t4_rst_done", int'(d0), 0);
    chk_vec("t4_rst_window", {128'b0, w0}, '0);
    rst = 1'b0;
    clear_q();
    drive(0, 0, 16);
    repeat (12) tick();
    check_frame("t4_replay", 0, 1);

    // 5x5 kernel
    clear_q();
    drive(1, 0, 25);
    repeat (20) tick();
    check_frame("t5_k5", 2, 1);
    s2 = q2;

    // back-to-back frames
    clear_q();
    drive(0, 0, 16);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (d0) found = 1;
    end
    chk_int("t6_done_seen", found, 1);
    drive(0, 0, 16);
    repeat (12) tick();
    check_frame("t6_b2b_zero", 0, 2);
    check_frame("t6_b2b_rep", 1, 2);

    // random images with random input gaps
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) img_a[r][c] = int'($urandom_range(0, 255));
      clear_q();
      drive(0, 2, 16);
      repeat (12) tick();
      check_frame($sformatf("rnd%0d_zero", f), 0, 1);
      check_frame($sformatf("rnd%0d_rep", f), 1, 1);
    end

    // literal windows
    for (int j = 0; j < tbl.size(); j++) begin
      act = -1;
      case (tbl[j].dut)
        0: if (tbl[j].win < s0.size()) begin wv = s0[tbl[j].win].win; act = int'(wv[tbl[j].tap*8 +: 8]); end
        1: if (tbl[j].win < s1.size()) begin wv = s1[tbl[j].win].win; act = int'(wv[tbl[j].tap*8 +: 8]); end
        default: if (tbl[j].win < s2.size()) begin wv = s2[tbl[j].win].win; act = int'(wv[tbl[j].tap*8 +: 8]); end
      endcase
      chk_int($sformatf("tbl_d%0d_w%0d_t%0d", tbl[j].dut, tbl[j].win, tbl[j].tap), act, tbl[j].exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
